// File: rtl/mdu_sequencer_pkg.sv
// Shared MIPS definitions: ALU operation codes and the multiply/divide opcode enum.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } mdu_op_t;

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/result bundle between the EX stage and the multiply/divide sequencer.
interface mdu_sequencer_if #(parameter int WIDTH = 32);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, rs_val, rt_val,
                  input  busy, done, div_zero, hi, lo);

  modport slave  (input  start, op, rs_val, rt_val,
                  output busy, done, div_zero, hi, lo);

endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer; all arithmetic goes through the shared external ALU,
// signed operands are reduced to magnitudes first and the signs are reapplied at the end.
module mdu_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  mdu_sequencer_if.slave   mdu,
  output logic [3:0]       alu_opCode,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  input  logic [WIDTH-1:0] alu_Out,
  input  logic             alu_zero
);

  typedef enum logic [2:0] {
    IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE
  } mdu_state_t;

  mdu_state_t       state, state_nx;
  mdu_op_t          op_q, op_nx;
  logic [WIDTH-1:0] a_q, a_nx, b_q, b_nx;
  logic [WIDTH-1:0] hi_q, hi_nx, lo_q, lo_nx;
  logic [WIDTH-1:0] hi_eff, lo_eff, rem_sh;
  logic [CNT_W-1:0] cnt;
  logic             s_a, s_b, lo_zero, div_zero_q, dz_nx;
  logic             is_mul, is_signed, neg, cnt_last, carry, take;

  assign is_mul    = (op_q == MULT) || (op_q == MULTU);
  assign is_signed = (op_q == MULT) || (op_q == DIV);
  assign neg       = s_a ^ s_b;
  assign cnt_last  = (cnt == CNT_W'(WIDTH - 1));

  // The first iteration sees the preload (hi=0, lo=multiplier or dividend) so hi/lo keep the
  // previous result until the new computation actually starts overwriting them.
  assign hi_eff = (cnt == '0) ? '0 : hi_q;
  assign lo_eff = (cnt == '0) ? (is_mul ? b_q : a_q) : lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    op_nx      = op_q;
    a_nx       = a_q;
    b_nx       = b_q;
    hi_nx      = hi_q;
    lo_nx      = lo_q;
    dz_nx      = div_zero_q;
    alu_opCode = ALU_ADD;
    alu_A      = '0;
    alu_B      = '0;
    carry      = 1'b0;
    take       = 1'b0;
    rem_sh     = '0;
    case (state)
      IDLE: begin
        if (mdu.start) begin
          op_nx    = mdu_op_t'(mdu.op);
          a_nx     = mdu.rs_val;
          b_nx     = mdu.rt_val;
          dz_nx    = mdu.op[1] && (mdu.rt_val == '0);
          state_nx = mdu.op[0] ? ITER : NEG_A;
        end
      end
      NEG_A: begin
        alu_opCode = ALU_SUB;
        alu_B      = a_q;
        if (a_q[WIDTH-1]) a_nx = alu_Out;
        state_nx   = NEG_B;
      end
      NEG_B: begin
        alu_opCode = ALU_SUB;
        alu_B      = b_q;
        if (b_q[WIDTH-1]) b_nx = alu_Out;
        state_nx   = ITER;
      end
      ITER: begin
        if (is_mul) begin
          alu_opCode = ALU_ADD;
          alu_A      = hi_eff;
          alu_B      = lo_eff[0] ? a_q : '0;
          carry      = (alu_Out < hi_eff);
          hi_nx      = {carry, alu_Out[WIDTH-1:1]};
          lo_nx      = {alu_Out[0], lo_eff[WIDTH-1:1]};
        end else begin
          // Restoring step: the bit shifted out of hi guarantees the subtract fits.
          rem_sh     = {hi_eff[WIDTH-2:0], lo_eff[WIDTH-1]};
          alu_opCode = ALU_SUB;
          alu_A      = rem_sh;
          alu_B      = b_q;
          take       = hi_eff[WIDTH-1] | (rem_sh >= b_q);
          hi_nx      = take ? alu_Out : rem_sh;
          lo_nx      = {lo_eff[WIDTH-2:0], take};
        end
        if (cnt_last) state_nx = is_signed ? FIX_LO : DONE;
      end
      FIX_LO: begin
        alu_opCode = ALU_SUB;
        alu_B      = lo_q;
        if (neg) lo_nx = alu_Out;
        state_nx   = FIX_HI;
      end
      FIX_HI: begin
        // A 64-bit negate only borrows into hi when lo was zero; otherwise hi is just inverted.
        if (is_mul && neg && !lo_zero) begin
          alu_opCode = ALU_NOR;
          alu_A      = hi_q;
          alu_B      = hi_q;
        end else begin
          alu_opCode = ALU_SUB;
          alu_B      = hi_q;
        end
        if (is_mul ? neg : s_a) hi_nx = alu_Out;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= MULT;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
      s_a        <= 1'b0;
      s_b        <= 1'b0;
      lo_zero    <= 1'b0;
      cnt        <= '0;
    end else begin
      op_q       <= op_nx;
      a_q        <= a_nx;
      b_q        <= b_nx;
      hi_q       <= hi_nx;
      lo_q       <= lo_nx;
      div_zero_q <= dz_nx;
      if (state == NEG_A)  s_a     <= a_q[WIDTH-1];
      if (state == NEG_B)  s_b     <= b_q[WIDTH-1];
      if (state == FIX_LO) lo_zero <= alu_zero;
      cnt <= (state == ITER) ? cnt + CNT_W'(1) : '0;
    end
  end

  assign mdu.busy     = (state != IDLE);
  assign mdu.done     = (state == DONE);
  assign mdu.div_zero = div_zero_q;
  assign mdu.hi       = hi_q;
  assign mdu.lo       = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: behavioural ALU, 64-bit arithmetic reference model, directed and random ops.
module tb_mdu_sequencer;
  import mips_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       alu_opCode;
  logic [WIDTH-1:0] alu_A, alu_B, alu_Out;
  logic             alu_zero;

  int errors  = 0;
  int checks  = 0;
  int mon_err = 0;
  int run_id  = 0;

  mdu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  mdu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mdu        (bus),
    .alu_opCode (alu_opCode),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_Out    (alu_Out),
    .alu_zero   (alu_zero)
  );

  always #5 clk = ~clk;

  // The shared ALU the parent would normally instance.
  always_comb begin
    case (alu_opCode)
      ALU_AND: alu_Out = alu_A & alu_B;
      ALU_OR:  alu_Out = alu_A | alu_B;
      ALU_ADD: alu_Out = alu_A + alu_B;
      ALU_SUB: alu_Out = alu_A - alu_B;
      ALU_SLT: alu_Out = {31'b0, $signed(alu_A) < $signed(alu_B)};
      ALU_NOR: alu_Out = ~(alu_A | alu_B);
      default: alu_Out = '0;
    endcase
    alu_zero = (alu_Out == '0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!(alu_opCode inside {ALU_ADD, ALU_SUB, ALU_NOR})) mon_err++;
      if (bus.done === 1'b1 && bus.busy !== 1'b1) mon_err++;
    end
  end

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin
          dz = 1'b1; hi = a; lo = a[31] ? 32'h1 : 32'hFFFF_FFFF;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
      default: begin
        if (b == 0) begin dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want)
      else begin
        errors++;
        $error("[TB] FAIL %s: got %0h want %0h", tag, got, want);
      end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int pulse_at, input int rst_at);
    int          edges;
    bit          seen;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_dz;
    run_id++;
    model(op, a, b, exp_hi, exp_lo, exp_dz);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 2'($urandom); bus.rs_val = $urandom; bus.rt_val = $urandom;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (edges == rst_at) begin
        rst_n = 1'b0;
        #1;
        checkOutput($sformatf("run%0d_rst_busy", run_id), 64'(bus.busy), 64'(0));
        checkOutput($sformatf("run%0d_rst_done", run_id), 64'(bus.done), 64'(0));
        checkOutput($sformatf("run%0d_rst_hi", run_id), 64'(bus.hi), 64'(0));
        checkOutput($sformatf("run%0d_rst_lo", run_id), 64'(bus.lo), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      bus.start = (edges == pulse_at);
      if (edges == pulse_at) begin
        bus.op = 2'($urandom); bus.rs_val = $urandom; bus.rt_val = $urandom;
      end
      seen = bus.done;
    end
    checkOutput($sformatf("run%0d_done_seen", run_id), 64'(seen), 64'(1));
    checkOutput($sformatf("run%0d_latency", run_id), 64'(edges), 64'(op[0] ? 32 : 36));
    checkOutput($sformatf("run%0d_hi", run_id), 64'(bus.hi), 64'(exp_hi));
    checkOutput($sformatf("run%0d_lo", run_id), 64'(bus.lo), 64'(exp_lo));
    checkOutput($sformatf("run%0d_div_zero", run_id), 64'(bus.div_zero), 64'(exp_dz));
    @(posedge clk); #1;
    checkOutput($sformatf("run%0d_done_width", run_id), 64'(bus.done), 64'(0));
    checkOutput($sformatf("run%0d_idle_busy", run_id), 64'(bus.busy), 64'(0));
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
    @(posedge clk); #1;
    checkOutput("reset_busy", 64'(bus.busy), 64'(0));
    checkOutput("reset_done", 64'(bus.done), 64'(0));
    checkOutput("reset_div_zero", 64'(bus.div_zero), 64'(0));
    checkOutput("reset_hi", 64'(bus.hi), 64'(0));
    checkOutput("reset_lo", 64'(bus.lo), 64'(0));
    checkOutput("reset_alu_op", 64'(alu_opCode), 64'(ALU_ADD));
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd7, -1, -1);
    applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    applyStimulus(2'b00, 32'h8000_0000, 32'd2, -1, -1);
    applyStimulus(2'b11, 32'd1000, 32'd200, -1, -1);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1);
    applyStimulus(2'b11, 32'd1000, 32'd0, -1, -1);
    applyStimulus(2'b11, 32'd1000, 32'd3, -1, -1);
    applyStimulus(2'b10, 32'hFFFF_FF00, 32'd0, -1, -1);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    applyStimulus(2'b01, 32'd123456, 32'd6789, 5, -1);
    applyStimulus(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, -1, 10);
    applyStimulus(2'b01, 32'd6, 32'd7, -1, -1);

    for (int i = 0; i < 12; i++) begin
      r_op = 2'($urandom);
      r_a  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      r_b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      if ($urandom_range(0, 3) == 0) r_b = -r_b;
      applyStimulus(r_op, r_a, r_b, -1, -1);
    end

    checkOutput("monitor_violations", 64'(mon_err), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
